vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Raster timing source for the 640x480@60 display path; the producer end of the DrawX/DrawY pixel-coordinate interface consumed by color_mapper.
- Divides the system clock into a pixel-enable and runs horizontal and vertical counters.
- Emits DrawX/DrawY to the mapper and sync/blank to the DAC.
- Sync/blank are delayed by a programmable number of pixel ticks so they line up with the mapper's registered RGB.

Parameters:
- CLK_DIV, 2: system clocks per pixel (50 MHz -> 25 MHz); must be >= 1.
- H_VISIBLE, 640: active pixels per line.
- H_FP, 16: horizontal front porch, pixels.
- H_SYNC, 96: horizontal sync width, pixels.
- H_BP, 48: horizontal back porch, pixels.
- V_VISIBLE, 480: active lines per frame.
- V_FP, 10: vertical front porch, lines.
- V_SYNC, 2: vertical sync width, lines.
- V_BP, 33: vertical back porch, lines.
- PIPE_DLY, 1: pixel-tick delay applied to hs_n/vs_n/blank_n; 0 means undelayed.

Ports:
- clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- pixel_en  out  1  one-clk pulse every CLK_DIV clocks; the pixel tick.
- DrawX  out  10  current horizontal counter, 0..H_TOTAL-1.
- DrawY  out  10  current vertical counter, 0..V_TOTAL-1.
- hs_n  out  1  horizontal sync, active low, delayed by PIPE_DLY ticks.
- vs_n  out  1  vertical sync, active low, delayed by PIPE_DLY ticks.
- blank_n  out  1  high in the visible region, delayed by PIPE_DLY ticks.
- frame_start  out  1  one-clk pulse at pixel (0,0).
- line_end  out  1  one-clk pulse on the last pixel of each line.

Behaviour:
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Clocking: one clock domain. Reset is synchronous and active-high, sampled on posedge clk; ports are named clk and Reset.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pixel_en = (div_cnt == CLK_DIV-1), registered.
  - With CLK_DIV=1, pixel_en is constantly 1 after reset.
- Counters advance only on pixel_en:
  - hc increments; when hc == H_TOTAL-1 it wraps to 0 and vc increments.
  - When vc == V_TOTAL-1 and hc wraps, vc wraps to 0.
  - DrawX = hc and DrawY = vc, raw and unclamped; the mapper masks non-visible coordinates via blank_n.
- Raw timing, combinational from hc/vc:
  - hs_raw = 0 when H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vs_raw = 0 when V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491).
  - blank_raw_n = (hc < H_VISIBLE) && (vc < V_VISIBLE).
- Delay line:
  - {hs_raw, vs_raw, blank_raw_n} shift through PIPE_DLY stages, advancing only on pixel_en.
  - Outputs are the last stage; with PIPE_DLY=0 they are the raw values.
- Pulses:
  - frame_start = 1 for the single clk in which pixel_en=1 and hc=0, vc=0.
  - line_end = 1 for the single clk in which pixel_en=1 and hc=H_TOTAL-1.
  - Both are 0 on all other clocks.
- Reset values, applied the cycle after Reset is sampled high:
  - div_cnt=0, hc=0, vc=0, pixel_en=0.
  - All delay stages hold {1,1,0}, so hs_n=1, vs_n=1, blank_n=0.
  - frame_start=0, line_end=0.
- Reset mid-frame: state returns to the values above on the next edge regardless of position. After release, the first pixel_en occurs CLK_DIV clocks later, at hc=0, vc=0, and asserts frame_start.
- Reset held high: all state is frozen at reset values; no pulses.
- Simultaneous hc and vc wrap: both counters update on the same pixel_en; the frame is exactly H_TOTAL*V_TOTAL pixel ticks.
- Widths: 10-bit counters; H_TOTAL and V_TOTAL must be <= 1024 (elaboration-time assertion).

Decomposition:
- vga_timing_pkg holds:
  - default 640x480 timing constants;
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - the packed struct sync_t {hs_n, vs_n, blank_n}.
- One sub-module, sync_delay_line:
  - parameterised depth;
  - shift register of sync_t with enable and synchronous reset to {1,1,0}.

Test Plan:
- Reset 5 clks, release -> hs_n=1, vs_n=1, blank_n=0 during reset; first pixel_en 2 clks after release with DrawX=0, DrawY=0, frame_start=1 on that clk.
- Run one line, PIPE_DLY=0 -> hs_n low for exactly 96 pixel ticks starting at DrawX=656; blank_n high for DrawX 0..639; line_end pulses once, at DrawX=799.
- Run a full frame -> vs_n low exactly while DrawY is 490..491; DrawY wraps 524->0 together with DrawX 799->0; frame_start pulses are 800*525*2 = 840000 clks apart.
- PIPE_DLY=1 -> hs_n falls one pixel tick (2 clks) after DrawX reaches 656; blank_n falls when DrawX=641.
- Assert Reset for 1 clk at DrawX=300, DrawY=200 -> next clk shows DrawX=0, DrawY=0, hs_n=1, blank_n=0; the following frame timing is identical to the post-power-up timing.
- CLK_DIV=1 -> pixel_en constantly 1 after reset; frame period is 420000 clks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and sync payload type for the 640x480@60 raster path.
package vga_timing_pkg;

   // Counter width shared by DrawX/DrawY; totals must fit in it.
   localparam int unsigned CNT_W     = 10;
   localparam int unsigned MAX_TOTAL = 1024;

   // Default 640x480@60 timing, 25 MHz pixel clock from 50 MHz.
   localparam int unsigned DEF_CLK_DIV   = 2;
   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_FP      = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BP      = 48;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_FP      = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BP      = 33;
   localparam int unsigned DEF_PIPE_DLY  = 1;

   // Derived default totals and sync windows (start inclusive, end exclusive).
   localparam int unsigned H_TOTAL  = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int unsigned V_TOTAL  = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int unsigned HS_START = DEF_H_VISIBLE + DEF_H_FP;
   localparam int unsigned HS_END   = HS_START + DEF_H_SYNC;
   localparam int unsigned VS_START = DEF_V_VISIBLE + DEF_V_FP;
   localparam int unsigned VS_END   = VS_START + DEF_V_SYNC;

   // Sync/blank bundle carried through the alignment delay line.
   typedef struct packed {
      logic hs_n;
      logic vs_n;
      logic blank_n;
   } sync_t;

   // Idle value: syncs inactive, display blanked.
   localparam sync_t SYNC_RST = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0};

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Pixel-tick shift register that aligns sync/blank with the mapper's registered RGB.
module sync_delay_line
   import vga_timing_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic  i_clk,
   input  logic  i_rst,
   input  logic  i_en,
   input  sync_t i_sync,
   output sync_t o_sync
);

   if (DEPTH < 1) begin : g_bad_depth
      $error("sync_delay_line: DEPTH must be >= 1");
   end

   sync_t r_stage [DEPTH];

   // Shift one stage per pixel tick; reset loads the idle value into every stage.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_stage[i] <= SYNC_RST;
         end
      end else if (i_en) begin
         r_stage[0] <= i_sync;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_sync = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel-enable divider, h/v counters, delayed sync/blank and frame/line pulses.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
   parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned H_FP      = DEF_H_FP,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BP      = DEF_H_BP,
   parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
   parameter int unsigned V_FP      = DEF_V_FP,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BP      = DEF_V_BP,
   parameter int unsigned PIPE_DLY  = DEF_PIPE_DLY
) (
   input  logic             clk,
   input  logic             Reset,
   output logic             pixel_en,
   output logic [CNT_W-1:0] DrawX,
   output logic [CNT_W-1:0] DrawY,
   output logic             hs_n,
   output logic             vs_n,
   output logic             blank_n,
   output logic             frame_start,
   output logic             line_end
);

   localparam int unsigned H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_LO = H_VISIBLE + H_FP;
   localparam int unsigned HS_HI = HS_LO + H_SYNC;
   localparam int unsigned VS_LO = V_VISIBLE + V_FP;
   localparam int unsigned VS_HI = VS_LO + V_SYNC;
   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HC_LAST  = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] VC_LAST  = CNT_W'(V_TOT - 1);

   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be >= 1");
   end
   if (H_TOT > MAX_TOTAL || V_TOT > MAX_TOTAL) begin : g_bad_total
      $error("vga_timing_gen: H/V totals must fit 10-bit counters");
   end

   logic [DIV_W-1:0] r_div;
   logic             r_pixel_en;
   logic [CNT_W-1:0] r_hc;
   logic [CNT_W-1:0] r_vc;
   logic             r_frame_start;
   logic             r_line_end;

   logic [DIV_W-1:0] w_div_nxt;
   logic             w_pe_nxt;
   logic [CNT_W-1:0] w_hc_nxt;
   logic [CNT_W-1:0] w_vc_nxt;
   sync_t            w_raw;
   sync_t            w_sync;

   // Next divider and counter values; counters step on the registered pixel tick.
   always_comb begin
      w_pe_nxt  = (r_div == DIV_LAST);
      w_div_nxt = w_pe_nxt ? '0 : r_div + DIV_W'(1);
      w_hc_nxt  = r_hc;
      w_vc_nxt  = r_vc;
      if (r_pixel_en) begin
         if (r_hc == HC_LAST) begin
            w_hc_nxt = '0;
            w_vc_nxt = (r_vc == VC_LAST) ? '0 : r_vc + CNT_W'(1);
         end else begin
            w_hc_nxt = r_hc + CNT_W'(1);
         end
      end
   end

   // State registers; pulses are pre-computed so they coincide with pixel_en at the target pixel.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_div         <= '0;
         r_pixel_en    <= 1'b0;
         r_hc          <= '0;
         r_vc          <= '0;
         r_frame_start <= 1'b0;
         r_line_end    <= 1'b0;
      end else begin
         r_div         <= w_div_nxt;
         r_pixel_en    <= w_pe_nxt;
         r_hc          <= w_hc_nxt;
         r_vc          <= w_vc_nxt;
         r_frame_start <= w_pe_nxt && (w_hc_nxt == '0) && (w_vc_nxt == '0);
         r_line_end    <= w_pe_nxt && (w_hc_nxt == HC_LAST);
      end
   end

   // Undelayed sync/blank decoded from the current counter position.
   always_comb begin
      w_raw         = SYNC_RST;
      w_raw.hs_n    = !((r_hc >= CNT_W'(HS_LO)) && (r_hc < CNT_W'(HS_HI)));
      w_raw.vs_n    = !((r_vc >= CNT_W'(VS_LO)) && (r_vc < CNT_W'(VS_HI)));
      w_raw.blank_n = (r_hc < CNT_W'(H_VISIBLE)) && (r_vc < CNT_W'(V_VISIBLE));
   end

   if (PIPE_DLY == 0) begin : g_no_dly
      assign w_sync = w_raw;
   end else begin : g_dly
      sync_delay_line #(
         .DEPTH (PIPE_DLY)
      ) u_sync_dly (
         .i_clk  (clk),
         .i_rst  (Reset),
         .i_en   (r_pixel_en),
         .i_sync (w_raw),
         .o_sync (w_sync)
      );
   end

   assign pixel_en    = r_pixel_en;
   assign DrawX       = r_hc;
   assign DrawY       = r_vc;
   assign hs_n        = w_sync.hs_n;
   assign vs_n        = w_sync.vs_n;
   assign blank_n     = w_sync.blank_n;
   assign frame_start = r_frame_start;
   assign line_end    = r_line_end;

endmodule
